// File: rtl/mem_responder.sv
// mem_responder: byte-wide RAM responder with a UART TX FIFO, an RX holding register and a status/control byte.
// Optional feature macro MEM_RESPONDER_HALT_EN adds a sim_halt output requested by a control write of 8'hFF.
module mem_responder #(
   parameter int          ADDR_W     = 17,
   parameter logic [31:0] IO_ADDR    = 32'h0003_0000,
   parameter logic [31:0] STAT_ADDR  = 32'h0003_0004,
   parameter int          FIFO_DEPTH = 8,
   parameter string       INIT_FILE  = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ram_addr,
   input  logic        ram_writing,
   input  logic [7:0]  ram_data,
   output logic [7:0]  ram_loaded_data,
   output logic        io_stall,
`ifdef MEM_RESPONDER_HALT_EN
   output logic        sim_halt,
`endif
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   logic [7:0]        mem [2**ADDR_W];
   logic [7:0]        fifo [FIFO_DEPTH];
   logic [PTR_W-1:0]  head, tail;
   logic [CNT_W-1:0]  count, count_next;
   logic [7:0]        rx_buf;
   logic              rx_full, overrun;
   logic [ADDR_W-1:0] idx;
   logic io_hit, st_hit, ram_hit, tx_full, push_req, push, pop, tx_drop;
   logic ctrl_write, flush, rx_pop, rx_load, rx_drop, stat_read;

   // Address decode; everything outside the two I/O bytes aliases into the RAM
   assign io_hit    = (ram_addr == IO_ADDR);
   assign st_hit    = (ram_addr == STAT_ADDR);
   assign ram_hit   = !io_hit && !st_hit;
   assign idx       = ram_addr[ADDR_W-1:0];
   assign stat_read = !ram_writing && st_hit;

   assign tx_valid = (count != '0);
   assign tx_data  = tx_valid ? fifo[head] : 8'h00;
   assign tx_full  = (count == DEPTH_C);
   assign pop      = tx_valid && tx_ready;
   assign push_req = ram_writing && io_hit;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
   assign push     = push_req && (!tx_full || pop);
   assign tx_drop  = push_req && tx_full && !pop;

   assign rx_pop  = !ram_writing && io_hit;
   assign rx_load = rx_valid && (!rx_full || rx_pop);
   assign rx_drop = rx_valid && rx_full && !rx_pop;

`ifdef MEM_RESPONDER_HALT_EN
   logic halt_req, halt_cmd;

   assign ctrl_write = ram_writing && st_hit && !sim_halt;
   assign halt_cmd   = ctrl_write && (ram_data == 8'hFF);
   assign flush      = ctrl_write && ram_data[0] && !halt_cmd;

   // Halt waits for the TX FIFO to drain so no queued byte is lost
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         halt_req <= 1'b0;
         sim_halt <= 1'b0;
      end else begin
         if (halt_cmd) halt_req <= 1'b1;
         if (halt_req && (count == '0)) sim_halt <= 1'b1;
      end
   end
`else
   assign ctrl_write = ram_writing && st_hit;
   assign flush      = ctrl_write && ram_data[0];
`endif

   always_comb begin
      count_next = count;
      if (flush)              count_next = '0;
      else if (push && !pop)  count_next = count + CNT_W'(1);
      else if (pop && !push)  count_next = count - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         io_stall <= 1'b0;
      end else begin
         count    <= count_next;
         io_stall <= (count_next >= DEPTH_C - CNT_W'(1));
         if (flush) begin
            head <= '0;
            tail <= '0;
         end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo[tail] <= ram_data;
   end

   always_ff @(posedge clk) begin
      if (ram_writing && ram_hit) mem[idx] <= ram_data;
   end

   always_ff @(posedge clk) begin
      if (rx_load) rx_buf <= rx_data;
   end

   // Read data mux, RX holding flag and sticky overrun; writes leave the read byte untouched
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ram_loaded_data <= 8'h00;
         rx_full         <= 1'b0;
         overrun         <= 1'b0;
      end else begin
         if (!ram_writing) begin
            if (ram_hit)     ram_loaded_data <= mem[idx];
            else if (io_hit) ram_loaded_data <= rx_full ? rx_buf : 8'h00;
            else             ram_loaded_data <= {5'b0, overrun, tx_full, rx_full};
         end
         if (rx_load)     rx_full <= 1'b1;
         else if (rx_pop) rx_full <= 1'b0;
         if (tx_drop || rx_drop) overrun <= 1'b1;
         else if (stat_read)     overrun <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scenarios plus a randomized run against a queue-based reference model.
module tb_mem_responder;
   localparam logic [31:0] IO_ADDR   = 32'h0003_0000;
   localparam logic [31:0] STAT_ADDR = 32'h0003_0004;
   localparam logic [31:0] IDLE_ADDR = 32'h0001_FFF0;
   localparam int          DEPTH     = 8;

   logic        clk, rst;
   logic [31:0] ram_addr;
   logic        ram_writing;
   logic [7:0]  ram_data, ram_loaded_data, tx_data, rx_data;
   logic        io_stall, tx_valid, tx_ready, rx_valid;
`ifdef MEM_RESPONDER_HALT_EN
   logic        sim_halt;
`endif

   int checks = 0;
   int fails  = 0;

   // Reference model state
   logic [7:0] mem_m [int];
   logic [7:0] q [$];
   bit         m_rxf, m_ovr, m_stall, m_hreq, m_halt;
   logic [7:0] m_rxb, m_rd;

   mem_responder dut (
      .clk(clk), .rst(rst), .ram_addr(ram_addr), .ram_writing(ram_writing),
      .ram_data(ram_data), .ram_loaded_data(ram_loaded_data), .io_stall(io_stall),
`ifdef MEM_RESPONDER_HALT_EN
      .sim_halt(sim_halt),
`endif
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .rx_valid(rx_valid), .rx_data(rx_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      q.delete();
      m_rxf = 0; m_ovr = 0; m_stall = 0; m_hreq = 0; m_halt = 0;
      m_rxb = 8'h00; m_rd = 8'h00;
   endtask

   // One clock of the port behaviour, evaluated from the inputs currently driven
   task automatic model_step();
      bit io, st, hit, pop, ovr, rxpop, ctrl;
      int osize;
      logic [7:0] rd;
      io = (ram_addr == IO_ADDR);
      st = (ram_addr == STAT_ADDR);
      hit = !io && !st;
      osize = q.size();
      pop = (osize != 0) && tx_ready;
      rxpop = !ram_writing && io;
      ovr = 0;
      rd = m_rd;
      if (ram_writing && hit) mem_m[int'(ram_addr[16:0])] = ram_data;
      if (!ram_writing && hit) rd = mem_m.exists(int'(ram_addr[16:0])) ? mem_m[int'(ram_addr[16:0])] : 8'h00;
      if (rxpop) rd = m_rxf ? m_rxb : 8'h00;
      if (!ram_writing && st) rd = {5'b0, m_ovr, osize == DEPTH, m_rxf};
      if (pop) void'(q.pop_front());
      if (ram_writing && io) begin
         if (q.size() < DEPTH) q.push_back(ram_data);
         else ovr = 1;
      end
      ctrl = ram_writing && st;
`ifdef MEM_RESPONDER_HALT_EN
      if (m_halt) ctrl = 0;
      m_halt = m_halt || (m_hreq && osize == 0);
      if (ctrl && ram_data == 8'hFF) begin
         m_hreq = 1;
         ctrl = 0;
      end
`endif
      if (ctrl && ram_data[0]) q.delete();
      if (rx_valid) begin
         if (!m_rxf || rxpop) begin
            m_rxb = rx_data;
            m_rxf = 1;
         end else ovr = 1;
      end else if (rxpop) m_rxf = 0;
      if (!ram_writing && st) m_ovr = ovr;
      else m_ovr = m_ovr || ovr;
      m_rd = rd;
      m_stall = (q.size() >= DEPTH - 1);
   endtask

   // Drive one port access, advance the model, land 1 time unit after the edge
   task automatic apply(input logic [31:0] a, input bit w, input logic [7:0] d);
      ram_addr = a;
      ram_writing = w;
      ram_data = d;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      ram_addr = IDLE_ADDR; ram_writing = 1'b1; ram_data = 8'h00;
      tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      checks++;
      if ({ram_loaded_data, io_stall, tx_valid, tx_data} !== 19'h0) begin
         fails++;
         $display("FAIL reset_outputs: rd=%h stall=%b txv=%b txd=%h, required all zero",
                  ram_loaded_data, io_stall, tx_valid, tx_data);
      end
      rst = 1'b1;
      apply(STAT_ADDR, 0, 8'h00);
      checks++;
      if (ram_loaded_data !== 8'h00) begin
         fails++;
         $display("FAIL reset_status: got %h, required 00", ram_loaded_data);
      end
   endtask

   task automatic test_ram();
      apply(32'h0000_0010, 1, 8'hA5);
      checks++;
      if (ram_loaded_data !== 8'h00) begin
         fails++;
         $display("FAIL ram_write_holds: got %h, required 00", ram_loaded_data);
      end
      apply(32'h0000_0010, 0, 8'h00);
      checks++;
      if (ram_loaded_data !== 8'hA5) begin
         fails++;
         $display("FAIL ram_read: got %h, required a5", ram_loaded_data);
      end
      apply(32'h0000_0011, 1, 8'h3C);
      apply(32'h0002_0010, 0, 8'h00);
      checks++;
      if (ram_loaded_data !== 8'hA5) begin
         fails++;
         $display("FAIL ram_alias: got %h, required a5", ram_loaded_data);
      end
   endtask

   task automatic test_tx_fill();
      tx_ready = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         apply(IO_ADDR, 1, 8'h80 + 8'(i));
         checks++;
         if (io_stall !== (i >= 7)) begin
            fails++;
            $display("FAIL tx_fill_stall[%0d]: got %b, required %b", i, io_stall, i >= 7);
         end
      end
      apply(IO_ADDR, 1, 8'hEE);
      apply(STAT_ADDR, 0, 8'h00);
      checks++;
      if (ram_loaded_data !== 8'b0000_0110) begin
         fails++;
         $display("FAIL tx_full_status: got %b, required 00000110", ram_loaded_data);
      end
      checks++;
      if (tx_data !== 8'h81 || tx_valid !== 1'b1) begin
         fails++;
         $display("FAIL tx_head: got v=%b d=%h, required v=1 d=81", tx_valid, tx_data);
      end
      apply(STAT_ADDR, 1, 8'h01);
      checks++;
      if (tx_valid !== 1'b0 || io_stall !== 1'b0 || tx_data !== 8'h00) begin
         fails++;
         $display("FAIL tx_flush: got v=%b stall=%b d=%h, required 0 0 00", tx_valid, io_stall, tx_data);
      end
      apply(STAT_ADDR, 0, 8'h00);
      checks++;
      if (ram_loaded_data !== 8'h00) begin
         fails++;
         $display("FAIL overrun_cleared: got %h, required 00", ram_loaded_data);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] seq [3];
      seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
      tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         apply(IO_ADDR, 1, seq[i]);
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== seq[i] || io_stall !== 1'b0) begin
            fails++;
            $display("FAIL b2b_data[%0d]: got v=%b d=%h stall=%b, required v=1 d=%h stall=0",
                     i, tx_valid, tx_data, io_stall, seq[i]);
         end
      end
      apply(IDLE_ADDR, 1, 8'h00);
      checks++;
      if (tx_valid !== 1'b0) begin
         fails++;
         $display("FAIL b2b_drain: tx_valid=%b, required 0", tx_valid);
      end
      tx_ready = 1'b0;
   endtask

   task automatic test_rx();
      rx_valid = 1'b1; rx_data = 8'h5A;
      apply(IDLE_ADDR, 1, 8'h00);
      rx_data = 8'h6B;
      apply(IDLE_ADDR, 1, 8'h00);
      rx_valid = 1'b0;
      apply(IO_ADDR, 0, 8'h00);
      checks++;
      if (ram_loaded_data !== 8'h5A) begin
         fails++;
         $display("FAIL rx_pop: got %h, required 5a", ram_loaded_data);
      end
      apply(STAT_ADDR, 0, 8'h00);
      checks++;
      if (ram_loaded_data !== 8'h04) begin
         fails++;
         $display("FAIL rx_overrun_status: got %h, required 04", ram_loaded_data);
      end
      apply(STAT_ADDR, 0, 8'h00);
      checks++;
      if (ram_loaded_data !== 8'h00) begin
         fails++;
         $display("FAIL rx_status_cleared: got %h, required 00", ram_loaded_data);
      end
      apply(IO_ADDR, 0, 8'h00);
      checks++;
      if (ram_loaded_data !== 8'h00) begin
         fails++;
         $display("FAIL rx_empty_read: got %h, required 00", ram_loaded_data);
      end
   endtask

   task automatic test_reset_mid();
      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) apply(IO_ADDR, 1, 8'(8'h40 + i));
      rx_valid = 1'b1; rx_data = 8'h77;
      apply(IDLE_ADDR, 1, 8'h00);
      rx_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      checks++;
      if (tx_valid !== 1'b0 || io_stall !== 1'b0 || tx_data !== 8'h00) begin
         fails++;
         $display("FAIL async_reset: got v=%b stall=%b d=%h, required 0 0 00", tx_valid, io_stall, tx_data);
      end
      model_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      apply(STAT_ADDR, 0, 8'h00);
      checks++;
      if (ram_loaded_data !== 8'h00) begin
         fails++;
         $display("FAIL reset_mid_status: got %h, required 00", ram_loaded_data);
      end
   endtask

   task automatic test_random();
      int r;
      logic [31:0] a;
      bit w;
      logic [7:0] d, exp_txd;
      for (int i = 0; i < 16; i++) apply(32'(i), 1, 8'($urandom));
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 9);
         if (r < 5) a = ($urandom_range(0, 1) ? 32'h0002_0000 : 32'h0) | 32'($urandom_range(0, 15));
         else if (r < 8) a = IO_ADDR;
         else a = STAT_ADDR;
         w = 1'($urandom_range(0, 1));
         d = 8'($urandom);
         if (a == STAT_ADDR && w) d = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00;
         tx_ready = ($urandom_range(0, 2) == 0);
         rx_valid = ($urandom_range(0, 3) == 0);
         rx_data = 8'($urandom);
         apply(a, w, d);
         exp_txd = (q.size() != 0) ? q[0] : 8'h00;
         checks++;
         if (ram_loaded_data !== m_rd || tx_valid !== (q.size() != 0) ||
             tx_data !== exp_txd || io_stall !== m_stall) begin
            fails++;
            $display("FAIL random[%0d]: got rd=%h v=%b d=%h stall=%b, required rd=%h v=%b d=%h stall=%b",
                     n, ram_loaded_data, tx_valid, tx_data, io_stall, m_rd, q.size() != 0, exp_txd, m_stall);
         end
      end
      tx_ready = 1'b0;
      rx_valid = 1'b0;
   endtask

`ifdef MEM_RESPONDER_HALT_EN
   task automatic test_halt();
      rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      model_reset();
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) apply(IO_ADDR, 1, 8'(8'h60 + i));
      apply(STAT_ADDR, 1, 8'hFF);
      checks++;
      if (tx_valid !== 1'b1 || sim_halt !== 1'b0) begin
         fails++;
         $display("FAIL halt_no_flush: got v=%b halt=%b, required v=1 halt=0", tx_valid, sim_halt);
      end
      tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         apply(IDLE_ADDR, 1, 8'h00);
         checks++;
         if (sim_halt !== 1'b0) begin
            fails++;
            $display("FAIL halt_early[%0d]: got %b, required 0", i, sim_halt);
         end
      end
      for (int i = 0; i < 3; i++) begin
         apply(IDLE_ADDR, 1, 8'h00);
         checks++;
         if (sim_halt !== 1'b1) begin
            fails++;
            $display("FAIL halt_set[%0d]: got %b, required 1", i, sim_halt);
         end
      end
      tx_ready = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_ram();
      test_tx_fill();
      test_back_to_back();
      test_rx();
      test_reset_mid();
      test_random();
`ifdef MEM_RESPONDER_HALT_EN
      test_halt();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
